tlb_multiport: RTL and testbench
================================

Name: tlb_multiport

Overview:
Parametrised, fully associative joint TLB with N independent registered lookup ports. The array is shared across all ports; translation and probe logic is not replicated per array. Holds an internal Random/Wired replacement counter and services TLBWI/TLBWR/TLBR/TLBP from CP0. Sits between the fetch and memory stages and CP0, giving any number of MMU clients one coherent TLB.

Parameters:
ENTRIES, 16, number of TLB entries (power of two, 4..64)
N_PORTS, 2, number of lookup ports (1..4)
PABITS, 32, physical address width; PFN_W = PABITS-12
IDX_W, $clog2(ENTRIES), index width (derived)
CONF_W, 28+2*(PFN_W+5), entry width (derived; 78 at defaults)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
curr_asid  in  8  current ASID (EntryHi.ASID)
lk_req  in  N_PORTS  per-port lookup request
lk_vaddr  in  32*N_PORTS  per-port virtual address; port p at [32p+31:32p]
lk_rvalid  out  N_PORTS  result valid, one cycle after lk_req
lk_paddr  out  PABITS*N_PORTS  translated address
lk_miss  out  N_PORTS  no matching entry
lk_valid  out  N_PORTS  selected page V bit
lk_dirty  out  N_PORTS  selected page D bit
lk_uncached  out  N_PORTS  selected page C==3'd2
tlbwi  in  1  write entry at cp0_index
tlbwr  in  1  write entry at random_idx
tlbr  in  1  read entry at cp0_index
tlbp  in  1  probe using cp0_conf_in VPN2/ASID
cp0_index  in  IDX_W  Index register
cp0_wired  in  IDX_W  Wired register
cp0_wired_we  in  1  Wired being written this cycle
cp0_conf_in  in  CONF_W  {VPN2[19],ASID[8],G,PFN0,C0[3],D0,V0,PFN1,C1[3],D1,V1}, MSB first
cp0_conf_out  out  CONF_W  TLBR result
tlbr_done  out  1  pulse: cp0_conf_out updated
probe_done  out  1  pulse: probe result updated
probe_miss  out  1  probe found no match
probe_index  out  IDX_W  lowest matching index
random_idx  out  IDX_W  current Random value

Behaviour:
- Reset (rst=0, async): all entries zeroed, so every V=0 and G=0. random_idx=ENTRIES-1. All lk_* outputs 0. cp0_conf_out=0. probe_miss=1, probe_index=0. All done pulses 0.
- Match rule, entry i: VPN2_i==vaddr[31:13] && (G_i || ASID_i==curr_asid). Page select is vaddr[12]: 0 selects PFN0/C0/D0/V0, 1 selects PFN1/C1/D1/V1.
- Multiple hits: the lowest index wins. No error is flagged.
- Lookup latency is exactly 1 cycle. The compare runs combinationally in the request cycle against current array contents. Results are registered.
- lk_paddr = {PFN_sel, vaddr[11:0]}.
- On a miss: lk_miss=1, lk_valid/dirty/uncached=0, lk_paddr=0.
- Without lk_req, lk_rvalid=0 and the other lk_* outputs hold their previous values. Ports are fully pipelined: one request per port per cycle, no stalls.
- Command priority when several commands are asserted together: tlbwi > tlbwr > tlbr > tlbp. Only the winner executes; the others are dropped.
- Write (tlbwi/tlbwr): the entry is updated at the clock edge. The write is not visible to lookups or probes issued in the same cycle, and is visible from the next cycle.
- tlbr: cp0_conf_out = entry[cp0_index], registered, with tlbr_done high for 1 cycle.
- tlbp: compares cp0_conf_in[CONF_W-1 -: 19] and the ASID field. Result is registered. probe_done is high for 1 cycle. On a miss, probe_index holds its previous value.
- Out-of-range index (cp0_index >= ENTRIES, only possible if IDX_W is overridden): command ignored; no done pulse.
- Random counter: decrements every cycle.
  - If random_idx==cp0_wired (or 0), next value is ENTRIES-1.
  - cp0_wired_we forces ENTRIES-1 on the next cycle.
  - If cp0_wired>=ENTRIES-1, random_idx holds at ENTRIES-1.
  - tlbwr uses the pre-edge value. Random never enters [0, wired-1] after one wrap.
- Reset mid-operation: pending lookup results and done pulses are discarded. All state returns to reset values immediately.

Test Plan:
- Reset, then port0 lookup at 0x00401234 -> next cycle lk_rvalid[0]=1, lk_miss[0]=1, paddr 0.
- tlbwi at index 3 with VPN2=0x00200 (covers 0x00400000-0x00401FFF), ASID=5, G=0, PFN0=0x12345 C0=3 D0=1 V0=1, PFN1=0x0ABCD C1=2 V1=1, curr_asid=5. Then port0 reads 0x00400ABC and port1 reads 0x00401FF0 in the same cycle -> port0: paddr 0x12345ABC, dirty=1, uncached=0; port1: paddr 0x0ABCDFF0, uncached=1, dirty=0.
- Same entry, curr_asid=6 -> miss. Rewrite with G=1 -> hit.
- tlbwi at index 3 and a port0 lookup in the same cycle -> lookup reports the old contents (miss); a lookup the following cycle hits.
- Identical VPN2 at indices 2 and 7, tlbp -> probe_done pulse, probe_miss=0, probe_index=2.
- Wired=4 written -> random_idx=15 next cycle, then counts 14,13,...,4,15,... Run tlbwr for 30 cycles -> no write lands in indices 0-3.

Source files
------------

// File: rtl/tlb_multiport.sv
// Fully associative joint TLB shared by N registered lookup ports, serving
// CP0 TLBWI/TLBWR/TLBR/TLBP and keeping the Random replacement counter.
module tlb_multiport #(
    parameter int ENTRIES = 16,
    parameter int N_PORTS = 2,
    parameter int PABITS  = 32,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int CONF_W  = 28 + 2 * (PABITS - 12 + 5)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                curr_asid,
    input  logic [N_PORTS-1:0]        lk_req,
    input  logic [32*N_PORTS-1:0]     lk_vaddr,
    output logic [N_PORTS-1:0]        lk_rvalid,
    output logic [PABITS*N_PORTS-1:0] lk_paddr,
    output logic [N_PORTS-1:0]        lk_miss,
    output logic [N_PORTS-1:0]        lk_valid,
    output logic [N_PORTS-1:0]        lk_dirty,
    output logic [N_PORTS-1:0]        lk_uncached,
    input  logic                      tlbwi,
    input  logic                      tlbwr,
    input  logic                      tlbr,
    input  logic                      tlbp,
    input  logic [IDX_W-1:0]          cp0_index,
    input  logic [IDX_W-1:0]          cp0_wired,
    input  logic                      cp0_wired_we,
    input  logic [CONF_W-1:0]         cp0_conf_in,
    output logic [CONF_W-1:0]         cp0_conf_out,
    output logic                      tlbr_done,
    output logic                      probe_done,
    output logic                      probe_miss,
    output logic [IDX_W-1:0]          probe_index,
    output logic [IDX_W-1:0]          random_idx
);
    localparam int PFN_W = PABITS - 12;
    localparam int PG_W  = PFN_W + 5;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(ENTRIES - 1);

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } match_t;

    // tag = {VPN2, ASID, G}
    function automatic logic entry_match(input logic [27:0] tag,
                                         input logic [18:0] vpn2,
                                         input logic [7:0]  asid);
        return (tag[27:9] == vpn2) && (tag[0] || (tag[8:1] == asid));
    endfunction

    function automatic match_t first_set(input logic [ENTRIES-1:0] v);
        match_t m;
        m = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (v[i]) begin
                m.hit = 1'b1;
                m.idx = IDX_W'(i);
            end
        end
        return m;
    endfunction

    function automatic logic [PG_W-1:0] sel_page(input logic [2*PG_W-1:0] pages,
                                                 input logic odd);
        return odd ? pages[PG_W-1:0] : pages[2*PG_W-1 -: PG_W];
    endfunction

    logic [CONF_W-1:0]  ent_q [ENTRIES];
    logic [CONF_W-1:0]  ent_d [ENTRIES];
    logic [ENTRIES-1:0] lk_hits [N_PORTS];
    match_t             lk_m [N_PORTS];
    logic [PG_W-1:0]    lk_pg [N_PORTS];
    logic [ENTRIES-1:0] probe_hits;
    match_t             probe_m;

    logic [N_PORTS-1:0] rvalid_d, rvalid_q, miss_d, miss_q, valid_d, valid_q;
    logic [N_PORTS-1:0] dirty_d, dirty_q, unc_d, unc_q;
    logic [PABITS-1:0]  paddr_d [N_PORTS];
    logic [PABITS-1:0]  paddr_q [N_PORTS];
    logic [CONF_W-1:0]  conf_out_d, conf_out_q;
    logic               tlbr_done_d, tlbr_done_q, probe_done_d, probe_done_q;
    logic               probe_miss_d, probe_miss_q;
    logic [IDX_W-1:0]   probe_idx_d, probe_idx_q, rand_d, rand_q;
    logic               idx_ok, do_wi, do_wr, do_r, do_p;
    logic [IDX_W-1:0]   wr_idx;

    // Lookups and probes compare against pre-edge contents, so a same-cycle write is not seen
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            for (int i = 0; i < ENTRIES; i++) begin
                lk_hits[p][i] = entry_match(ent_q[i][CONF_W-1 -: 28],
                                            lk_vaddr[32*p+13 +: 19], curr_asid);
            end
            lk_m[p]  = first_set(lk_hits[p]);
            lk_pg[p] = sel_page(ent_q[lk_m[p].idx][2*PG_W-1:0], lk_vaddr[32*p+12]);
        end
        for (int i = 0; i < ENTRIES; i++) begin
            probe_hits[i] = entry_match(ent_q[i][CONF_W-1 -: 28],
                                        cp0_conf_in[CONF_W-1 -: 19],
                                        cp0_conf_in[CONF_W-20 -: 8]);
        end
        probe_m = first_set(probe_hits);
    end

    always_comb begin
        rvalid_d = lk_req;
        miss_d   = miss_q;
        valid_d  = valid_q;
        dirty_d  = dirty_q;
        unc_d    = unc_q;
        paddr_d  = paddr_q;
        for (int p = 0; p < N_PORTS; p++) begin
            if (lk_req[p]) begin
                miss_d[p]  = !lk_m[p].hit;
                valid_d[p] = lk_m[p].hit & lk_pg[p][0];
                dirty_d[p] = lk_m[p].hit & lk_pg[p][1];
                unc_d[p]   = lk_m[p].hit & (lk_pg[p][4:2] == 3'd2);
                paddr_d[p] = lk_m[p].hit ? {lk_pg[p][PG_W-1 -: PFN_W], lk_vaddr[32*p +: 12]}
                                         : '0;
            end
        end
    end

    // One command per cycle; lower-priority commands are dropped
    always_comb begin
        idx_ok = int'(cp0_index) < ENTRIES;
        do_wi  = tlbwi & idx_ok;
        do_wr  = !tlbwi & tlbwr;
        do_r   = !tlbwi & !tlbwr & tlbr & idx_ok;
        do_p   = !tlbwi & !tlbwr & !tlbr & tlbp;
        wr_idx = tlbwi ? cp0_index : rand_q;

        ent_d = ent_q;
        if (do_wi || do_wr) ent_d[wr_idx] = cp0_conf_in;

        conf_out_d   = do_r ? ent_q[cp0_index] : conf_out_q;
        tlbr_done_d  = do_r;
        probe_done_d = do_p;
        probe_miss_d = do_p ? !probe_m.hit : probe_miss_q;
        probe_idx_d  = (do_p && probe_m.hit) ? probe_m.idx : probe_idx_q;

        // Wrapping at or below Wired keeps Random out of the wired range
        if (cp0_wired_we || int'(cp0_wired) >= ENTRIES - 1 ||
            rand_q <= cp0_wired || rand_q == '0) begin
            rand_d = TOP_IDX;
        end else begin
            rand_d = rand_q - IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
            for (int p = 0; p < N_PORTS; p++) paddr_q[p] <= '0;
            rvalid_q     <= '0;
            miss_q       <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
            unc_q        <= '0;
            conf_out_q   <= '0;
            tlbr_done_q  <= 1'b0;
            probe_done_q <= 1'b0;
            probe_miss_q <= 1'b1;
            probe_idx_q  <= '0;
            rand_q       <= TOP_IDX;
        end else begin
            ent_q        <= ent_d;
            paddr_q      <= paddr_d;
            rvalid_q     <= rvalid_d;
            miss_q       <= miss_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            unc_q        <= unc_d;
            conf_out_q   <= conf_out_d;
            tlbr_done_q  <= tlbr_done_d;
            probe_done_q <= probe_done_d;
            probe_miss_q <= probe_miss_d;
            probe_idx_q  <= probe_idx_d;
            rand_q       <= rand_d;
        end
    end

    always_comb begin
        for (int p = 0; p < N_PORTS; p++) lk_paddr[PABITS*p +: PABITS] = paddr_q[p];
    end

    assign lk_rvalid    = rvalid_q;
    assign lk_miss      = miss_q;
    assign lk_valid     = valid_q;
    assign lk_dirty     = dirty_q;
    assign lk_uncached  = unc_q;
    assign cp0_conf_out = conf_out_q;
    assign tlbr_done    = tlbr_done_q;
    assign probe_done   = probe_done_q;
    assign probe_miss   = probe_miss_q;
    assign probe_index  = probe_idx_q;
    assign random_idx   = rand_q;

endmodule

// File: tb/tb_tlb_multiport.sv
// Scoreboard bench for tlb_multiport: directed scenarios plus random traffic
// checked against a flat-array TLB reference model.
module tb_tlb_multiport;
    localparam int ENT = 16;
    localparam int NP  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    curr_asid;
    logic [NP-1:0] lk_req;
    logic [63:0]   lk_vaddr;
    logic [NP-1:0] lk_rvalid, lk_miss, lk_valid, lk_dirty, lk_uncached;
    logic [63:0]   lk_paddr;
    logic          tlbwi, tlbwr, tlbr, tlbp, cp0_wired_we;
    logic [3:0]    cp0_index, cp0_wired, probe_index, random_idx;
    logic [77:0]   cp0_conf_in, cp0_conf_out;
    logic          tlbr_done, probe_done, probe_miss;

    tlb_multiport #(.ENTRIES(ENT), .N_PORTS(NP), .PABITS(32)) dut (
        .clk(clk), .rst(rst), .curr_asid(curr_asid),
        .lk_req(lk_req), .lk_vaddr(lk_vaddr), .lk_rvalid(lk_rvalid),
        .lk_paddr(lk_paddr), .lk_miss(lk_miss), .lk_valid(lk_valid),
        .lk_dirty(lk_dirty), .lk_uncached(lk_uncached),
        .tlbwi(tlbwi), .tlbwr(tlbwr), .tlbr(tlbr), .tlbp(tlbp),
        .cp0_index(cp0_index), .cp0_wired(cp0_wired), .cp0_wired_we(cp0_wired_we),
        .cp0_conf_in(cp0_conf_in), .cp0_conf_out(cp0_conf_out),
        .tlbr_done(tlbr_done), .probe_done(probe_done), .probe_miss(probe_miss),
        .probe_index(probe_index), .random_idx(random_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed { int due; logic miss, valid, dirty, unc; logic [31:0] paddr; } exp_lk_t;
    typedef struct packed { int due; logic miss; logic [3:0] idx; } exp_pr_t;
    typedef struct packed { int due; logic [77:0] conf; } exp_rd_t;

    exp_lk_t q0[$], q1[$];
    exp_pr_t pq[$];
    exp_rd_t rq[$];
    exp_lk_t last_lk [NP];
    exp_pr_t last_pr;
    exp_rd_t last_rd;

    logic [77:0] m_conf [ENT];
    logic [3:0]  rnd_m;
    logic [3:0]  probe_idx_m;
    int          cyc = 0;
    bit          run = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [77:0] make_conf(input logic [18:0] vpn2, input logic [7:0] asid,
                                              input logic g, input logic [19:0] pfn0,
                                              input logic [2:0] c0, input logic d0, input logic v0,
                                              input logic [19:0] pfn1, input logic [2:0] c1,
                                              input logic d1, input logic v1);
        return {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1};
    endfunction

    function automatic logic [18:0] pick_vpn2();
        case ($urandom_range(0, 3))
            0: return 19'h00200;
            1: return 19'h00300;
            2: return 19'h00500;
            default: return 19'h7FFFF;
        endcase
    endfunction

    function automatic logic [77:0] rand_conf();
        return make_conf(pick_vpn2(), 8'(5 + $urandom_range(0, 2)), 1'($urandom),
                         20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                         20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
    endfunction

    // Reference: scan entries in index order, first match wins; bit 12 picks the page
    function automatic exp_lk_t model_lookup(input logic [31:0] va);
        exp_lk_t r;
        logic [77:0] c;
        logic [24:0] pg;
        r = '0;
        r.miss = 1'b1;
        for (int i = 0; i < ENT; i++) begin
            c = m_conf[i];
            if (c[77:59] == va[31:13] && (c[50] || c[58:51] == curr_asid)) begin
                pg = va[12] ? c[24:0] : c[49:25];
                r.miss  = 1'b0;
                r.valid = pg[0];
                r.dirty = pg[1];
                r.unc   = (pg[4:2] == 3'd2);
                r.paddr = {pg[24:5], va[11:0]};
                break;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENT; i++) m_conf[i] = '0;
        for (int p = 0; p < NP; p++) last_lk[p] = '0;
        rnd_m = 4'(ENT - 1);
        probe_idx_m = '0;
        last_pr = '0;
        last_pr.miss = 1'b1;
        last_rd = '0;
        q0.delete(); q1.delete(); pq.delete(); rq.delete();
    endtask

    // Called once per cycle with the inputs that the next rising edge will sample
    task automatic issue();
        exp_lk_t e;
        exp_pr_t pe;
        exp_rd_t re;
        logic [3:0] widx;
        bit wr, found;
        for (int p = 0; p < NP; p++) begin
            if (lk_req[p]) begin
                e = model_lookup(lk_vaddr[32*p +: 32]);
                e.due = cyc + 1;
                if (p == 0) q0.push_back(e); else q1.push_back(e);
            end
        end
        wr = 0;
        widx = '0;
        if (tlbwi) begin
            wr = 1; widx = cp0_index;
        end else if (tlbwr) begin
            wr = 1; widx = rnd_m;
        end else if (tlbr) begin
            re.due = cyc + 1; re.conf = m_conf[cp0_index]; rq.push_back(re);
        end else if (tlbp) begin
            found = 0;
            for (int i = 0; i < ENT && !found; i++) begin
                if (m_conf[i][77:59] == cp0_conf_in[77:59] &&
                    (m_conf[i][50] || m_conf[i][58:51] == cp0_conf_in[58:51])) begin
                    found = 1;
                    probe_idx_m = 4'(i);
                end
            end
            pe.due = cyc + 1; pe.miss = !found; pe.idx = probe_idx_m; pq.push_back(pe);
        end
        if (wr) m_conf[widx] = cp0_conf_in;
        if (cp0_wired_we || rnd_m == cp0_wired || rnd_m == 0 || cp0_wired >= 4'(ENT - 1))
            rnd_m = 4'(ENT - 1);
        else
            rnd_m = rnd_m - 4'd1;
    endtask

    task automatic monitor_check();
        exp_lk_t e;
        exp_pr_t pe;
        exp_rd_t re;
        bit rdy;
        for (int p = 0; p < NP; p++) begin
            rdy = 0;
            e = last_lk[p];
            if (p == 0 && q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); rdy = 1; end
            if (p == 1 && q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); rdy = 1; end
            cmp($sformatf("lk_rvalid[%0d]", p), lk_rvalid[p], rdy);
            cmp($sformatf("lk_result[%0d] {miss,v,d,unc,paddr}", p),
                {lk_miss[p], lk_valid[p], lk_dirty[p], lk_uncached[p], lk_paddr[32*p +: 32]},
                {e.miss, e.valid, e.dirty, e.unc, e.paddr});
            last_lk[p] = e;
        end
        rdy = 0;
        pe = last_pr;
        if (pq.size() > 0 && pq[0].due == cyc) begin pe = pq.pop_front(); rdy = 1; end
        cmp("probe_done", probe_done, rdy);
        cmp("probe {miss,index}", {probe_miss, probe_index}, {pe.miss, pe.idx});
        last_pr = pe;
        rdy = 0;
        re = last_rd;
        if (rq.size() > 0 && rq[0].due == cyc) begin re = rq.pop_front(); rdy = 1; end
        cmp("tlbr_done", tlbr_done, rdy);
        cmp("cp0_conf_out", cp0_conf_out, re.conf);
        last_rd = re;
        cmp("random_idx", random_idx, rnd_m);
    endtask

    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (run) monitor_check();
    end

    task automatic idle_inputs();
        lk_req = '0; tlbwi = 0; tlbwr = 0; tlbr = 0; tlbp = 0; cp0_wired_we = 0;
    endtask

    task automatic next();
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic step();
        issue();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_vals(input string tag);
        cmp({tag, " lk_rvalid"}, lk_rvalid, 0);
        cmp({tag, " lk_paddr"}, lk_paddr, 0);
        cmp({tag, " lk_miss"}, lk_miss, 0);
        cmp({tag, " lk_valid"}, lk_valid, 0);
        cmp({tag, " lk_dirty"}, lk_dirty, 0);
        cmp({tag, " lk_uncached"}, lk_uncached, 0);
        cmp({tag, " cp0_conf_out"}, cp0_conf_out, 0);
        cmp({tag, " tlbr_done"}, tlbr_done, 0);
        cmp({tag, " probe_done"}, probe_done, 0);
        cmp({tag, " probe_miss"}, probe_miss, 1);
        cmp({tag, " probe_index"}, probe_index, 0);
        cmp({tag, " random_idx"}, random_idx, 15);
    endtask

    logic [77:0] conf_a, conf_b, conf_c;

    initial begin
        rst = 0; curr_asid = 0; lk_vaddr = '0; cp0_index = '0; cp0_wired = '0;
        cp0_conf_in = '0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");

        // Empty TLB: miss
        next(); rst = 1; run = 1;
        lk_req = 2'b01; lk_vaddr[31:0] = 32'h00401234;
        step();
        cmp("empty rvalid", lk_rvalid[0], 1);
        cmp("empty miss", lk_miss[0], 1);
        cmp("empty paddr", lk_paddr[31:0], 0);

        // Write entry 3 then translate both pages on two ports at once
        conf_a = make_conf(19'h00200, 8'd5, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1,
                           20'h0ABCD, 3'd2, 1'b0, 1'b1);
        next(); tlbwi = 1; cp0_index = 4'd3; cp0_conf_in = conf_a; step();
        next(); curr_asid = 8'd5; lk_req = 2'b11; lk_vaddr = {32'h00401FF0, 32'h00400ABC}; step();
        cmp("even page paddr", lk_paddr[31:0], 32'h12345ABC);
        cmp("even page {miss,dirty,unc}", {lk_miss[0], lk_dirty[0], lk_uncached[0]}, 3'b010);
        cmp("odd page paddr", lk_paddr[63:32], 32'h0ABCDFF0);
        cmp("odd page {miss,dirty,unc}", {lk_miss[1], lk_dirty[1], lk_uncached[1]}, 3'b001);

        // ASID mismatch misses; global entry hits
        next(); curr_asid = 8'd6; lk_req = 2'b01; lk_vaddr[31:0] = 32'h00400ABC; step();
        cmp("asid mismatch miss", lk_miss[0], 1);
        conf_a[50] = 1'b1;
        next(); tlbwi = 1; cp0_index = 4'd3; cp0_conf_in = conf_a; step();
        next(); lk_req = 2'b01; step();
        cmp("global hit miss", lk_miss[0], 0);
        cmp("global hit paddr", lk_paddr[31:0], 32'h12345ABC);

        // Write and lookup in the same cycle: old contents seen
        conf_b = make_conf(19'h00300, 8'd5, 1'b0, 20'h11111, 3'd3, 1'b0, 1'b1,
                           20'h22222, 3'd0, 1'b1, 1'b1);
        next(); curr_asid = 8'd5; tlbwi = 1; cp0_index = 4'd3; cp0_conf_in = conf_b;
        lk_req = 2'b01; lk_vaddr[31:0] = 32'h00600010; step();
        cmp("same-cycle write miss", lk_miss[0], 1);
        next(); lk_req = 2'b01; step();
        cmp("next-cycle hit miss", lk_miss[0], 0);
        cmp("next-cycle hit paddr", lk_paddr[31:0], 32'h11111010);

        // Duplicate VPN2 at 2 and 7: probe returns lowest
        conf_c = make_conf(19'h00500, 8'd5, 1'b0, 20'h33333, 3'd3, 1'b1, 1'b1,
                           20'h44444, 3'd3, 1'b1, 1'b1);
        next(); tlbwi = 1; cp0_index = 4'd2; cp0_conf_in = conf_c; step();
        next(); tlbwi = 1; cp0_index = 4'd7; cp0_conf_in = conf_c; step();
        next(); tlbp = 1; step();
        cmp("probe_done pulse", probe_done, 1);
        cmp("probe hit miss", probe_miss, 0);
        cmp("probe lowest index", probe_index, 2);

        // tlbr outranks tlbp
        next(); tlbr = 1; tlbp = 1; cp0_index = 4'd3; step();
        cmp("prio tlbr_done", tlbr_done, 1);
        cmp("prio probe_done", probe_done, 0);
        cmp("prio conf_out", cp0_conf_out, conf_b);

        // Wired=4, then tlbwr must never touch entries 0-3
        next(); cp0_wired = 4'd4; cp0_wired_we = 1; step();
        cmp("random after wired write", random_idx, 15);
        for (int n = 0; n < 30; n++) begin
            next(); tlbwr = 1; cp0_conf_in = rand_conf(); step();
        end
        next(); tlbr = 1; cp0_index = 4'd0; step();
        cmp("wired entry0", cp0_conf_out, 0);
        next(); tlbr = 1; cp0_index = 4'd1; step();
        cmp("wired entry1", cp0_conf_out, 0);
        next(); tlbr = 1; cp0_index = 4'd2; step();
        cmp("wired entry2", cp0_conf_out, conf_c);
        next(); tlbr = 1; cp0_index = 4'd3; step();
        cmp("wired entry3", cp0_conf_out, conf_b);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            next();
            curr_asid = 8'(5 + $urandom_range(0, 2));
            lk_req = 2'($urandom);
            for (int p = 0; p < NP; p++)
                lk_vaddr[32*p +: 32] = {pick_vpn2(), 13'($urandom)};
            r = $urandom_range(0, 15);
            tlbwi = (r == 0) || (r == 6);
            tlbwr = (r == 1) || (r == 6) || (r == 7);
            tlbr  = (r == 2) || (r == 3) || (r == 6) || (r == 7);
            tlbp  = (r == 4) || (r == 5) || (r >= 6 && r <= 8);
            cp0_index = 4'($urandom);
            cp0_conf_in = (r == 4) ? {pick_vpn2(), 8'(5 + $urandom_range(0, 2)), 51'($urandom)}
                                   : rand_conf();
            if ($urandom_range(0, 40) == 0) begin
                cp0_wired = 4'($urandom);
                cp0_wired_we = 1;
            end
            step();
        end

        next(); step();
        next(); step();
        cmp("scoreboard drained", q0.size() + q1.size() + pq.size() + rq.size(), 0);

        // Asynchronous reset while results are being presented
        next(); lk_req = 2'b11; tlbr = 1; cp0_index = 4'd3; step();
        rst = 0;
        run = 0;
        #1;
        chk_reset_vals("mid-op reset");
        model_reset();
        next(); rst = 1; run = 1; tlbr = 1; cp0_index = 4'd3; step();
        cmp("entry cleared by reset", cp0_conf_out, 0);
        cmp("tlbr_done after reset", tlbr_done, 1);
        next(); step();
        run = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
